// File: rtl/cic_integ_decim.sv
// Multichannel TDM CIC integrator cascade with per-channel decimation.
// One integrator stage per clock; per-stage, per-channel accumulator banks.
module cic_integ_decim #(
  parameter int unsigned IN_WIDTH              = 16,
  parameter int unsigned MIDDLE_WIDTH          = 37,
  parameter int unsigned CIC_CONFIG_DATA_WIDTH = 16,
  parameter int unsigned CIC_MAX_CHANNELS      = 16,
  parameter int unsigned NUM_STAGES            = 5
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [CIC_CONFIG_DATA_WIDTH-1:0] CIC_NUMSECS_reg,
  input  logic [CIC_CONFIG_DATA_WIDTH-1:0] CIC_DECIM_reg,
  input  logic                             Sync_Clr,
  input  logic [IN_WIDTH-1:0]              Data_In,
  input  logic                             Data_In_Valid,
  input  logic [3:0]                       Data_In_ChIdx,
  output logic [MIDDLE_WIDTH-1:0]          Data_Out,
  output logic                             Data_Out_Valid,
  output logic [3:0]                       Data_Out_ChIdx
);

  localparam int unsigned CW   = CIC_CONFIG_DATA_WIDTH;
  localparam int unsigned LAST = NUM_STAGES - 1;

  logic [MIDDLE_WIDTH-1:0] acc [NUM_STAGES][CIC_MAX_CHANNELS];
  logic [CW-1:0]           cnt [CIC_MAX_CHANNELS];

  logic [MIDDLE_WIDTH-1:0] pipe_data [NUM_STAGES];
  logic                    pipe_vld  [NUM_STAGES];
  logic [3:0]              pipe_ch   [NUM_STAGES];

  logic [MIDDLE_WIDTH-1:0] stg_in  [NUM_STAGES];
  logic [MIDDLE_WIDTH-1:0] stg_sum [NUM_STAGES];
  logic [MIDDLE_WIDTH-1:0] stg_out [NUM_STAGES];
  logic                    stg_vld [NUM_STAGES];
  logic [3:0]              stg_ch  [NUM_STAGES];

  logic [3:0]    last_ch;
  logic [CW-1:0] last_cnt;
  logic          emit;

  logic unused_cfg_bits;
  assign unused_cfg_bits = ^CIC_NUMSECS_reg[CW-1:NUM_STAGES];

  // Each stage reads its bank at the slot's own channel; the previous write to
  // that entry committed at an earlier edge, so back-to-back samples are safe.
  always_comb begin
    stg_in[0]  = {{(MIDDLE_WIDTH-IN_WIDTH){Data_In[IN_WIDTH-1]}}, Data_In};
    stg_vld[0] = Data_In_Valid;
    stg_ch[0]  = Data_In_ChIdx;
    for (int unsigned s = 1; s < NUM_STAGES; s++) begin
      stg_in[s]  = pipe_data[s-1];
      stg_vld[s] = pipe_vld[s-1];
      stg_ch[s]  = pipe_ch[s-1];
    end
    for (int unsigned s = 0; s < NUM_STAGES; s++) begin
      stg_sum[s] = acc[s][stg_ch[s]] + stg_in[s];
      stg_out[s] = CIC_NUMSECS_reg[s] ? stg_sum[s] : stg_in[s];
    end
  end

  // Counts at or above R-1 (after R shrinks) emit and restart.
  always_comb begin
    last_ch  = pipe_ch[LAST];
    last_cnt = cnt[last_ch];
    emit     = (CIC_DECIM_reg <= CW'(1)) || (last_cnt >= CIC_DECIM_reg - CW'(1));
  end

  always_ff @(posedge CLK) begin
    if (RST || Sync_Clr) begin
      for (int unsigned s = 0; s < NUM_STAGES; s++) begin
        pipe_data[s] <= '0;
        pipe_vld[s]  <= 1'b0;
        pipe_ch[s]   <= '0;
        for (int unsigned c = 0; c < CIC_MAX_CHANNELS; c++) begin
          acc[s][c] <= '0;
        end
      end
      for (int unsigned c = 0; c < CIC_MAX_CHANNELS; c++) begin
        cnt[c] <= '0;
      end
      Data_Out_Valid <= 1'b0;
    end else begin
      for (int unsigned s = 0; s < NUM_STAGES; s++) begin
        pipe_data[s] <= stg_out[s];
        pipe_vld[s]  <= stg_vld[s];
        pipe_ch[s]   <= stg_ch[s];
        if (stg_vld[s] && CIC_NUMSECS_reg[s]) begin
          acc[s][stg_ch[s]] <= stg_sum[s];
        end
      end
      if (pipe_vld[LAST]) begin
        cnt[last_ch] <= emit ? '0 : last_cnt + CW'(1);
      end
      Data_Out_Valid <= pipe_vld[LAST] && emit;
    end
  end

  // Output data and tag survive Sync_Clr; only RST zeroes them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Data_Out       <= '0;
      Data_Out_ChIdx <= '0;
    end else if (!Sync_Clr && pipe_vld[LAST] && emit) begin
      Data_Out       <= pipe_data[LAST];
      Data_Out_ChIdx <= last_ch;
    end
  end

endmodule
